// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: defaults, FSM states, requester ids.
package regfile_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes plus register-file write port and status outputs.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
);
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;
  logic              lsu_valid;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              lsu_ready;
  logic              rf_write_enable;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_write_data;
  logic              init_done;
  logic [CNT_W-1:0]  conflict_cnt;
  logic              last_grant;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, rf_write_enable, rf_rd, rf_write_data,
           init_done, conflict_cnt, last_grant
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, rf_write_enable, rf_rd, rf_write_data,
           init_done, conflict_cnt, last_grant
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       last_o
);
  logic last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == 1'(REQ_LSU)) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (|gnt_o) last_d = gnt_o[REQ_LSU];
    end
  end

  // Reset to LSU so the ALU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'(REQ_LSU);
    else     last_q <= last_d;
  end

  assign last_o = last_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port owner: clears x1..x(NREG-1) after reset, then round-robins ALU/LSU writebacks.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int REG_AW         = REG_AW_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CNT_W          = 16
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave wb
);
  localparam state_e ST_INIT = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e            state_q, state_d;
  logic [REG_AW-1:0] clr_idx_q, clr_idx_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              init_q, init_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt;
  logic              last_grant;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({wb.lsu_valid, wb.alu_valid}),
    .en_i   (state_q == ST_RUN),
    .gnt_o  (gnt),
    .last_o (last_grant)
  );

  assign sel_rd   = gnt[REQ_LSU] ? wb.lsu_rd   : wb.alu_rd;
  assign sel_data = gnt[REQ_LSU] ? wb.lsu_data : wb.alu_data;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    we_d      = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    init_d    = init_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        we_d      = 1'b1;
        rd_d      = clr_idx_q;
        data_d    = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) begin
          state_d = ST_RUN;
          init_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // x0 writes complete the handshake but never reach the regfile.
        if (|gnt && sel_rd != '0) begin
          we_d   = 1'b1;
          rd_d   = sel_rd;
          data_d = sel_data;
        end
        if (wb.alu_valid && wb.lsu_valid && cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_idx_q <= REG_AW'(1);
      we_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      init_q    <= CLEAR_ON_RESET ? 1'b0 : 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      init_q    <= init_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wb.alu_ready       = gnt[REQ_ALU];
  assign wb.lsu_ready       = gnt[REQ_LSU];
  assign wb.rf_write_enable = we_q;
  assign wb.rf_rd           = rd_q;
  assign wb.rf_write_data   = data_q;
  assign wb.init_done       = init_q;
  assign wb.conflict_cnt    = cnt_q;
  assign wb.last_grant      = last_grant;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: clear sequence, vector table, randomized model check, reset abort, saturation.
module tb_regfile_wb_arbiter;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk, rst;
  int   checks   = 0;
  int   failures = 0;

  regfile_wb_arbiter_if #(.XLEN(32), .REG_AW(5), .CNT_W(CNT_W)) ifc ();

  regfile_wb_arbiter #(.XLEN(32), .REG_AW(5), .CLEAR_ON_RESET(1'b1), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
    ifc.alu_valid = av; ifc.alu_rd = ard; ifc.alu_data = adat;
    ifc.lsu_valid = lv; ifc.lsu_rd = lrd; ifc.lsu_data = ldat;
  endtask

  task automatic check_reset();
    chk("rst_we",    64'(ifc.rf_write_enable), 64'(0));
    chk("rst_rd",    64'(ifc.rf_rd),           64'(0));
    chk("rst_data",  64'(ifc.rf_write_data),   64'(0));
    chk("rst_init",  64'(ifc.init_done),       64'(0));
    chk("rst_cnt",   64'(ifc.conflict_cnt),    64'(0));
    chk("rst_last",  64'(ifc.last_grant),      64'(1));
    chk("rst_ardy",  64'(ifc.alu_ready),       64'(0));
    chk("rst_lrdy",  64'(ifc.lsu_ready),       64'(0));
  endtask

  // Releases reset and follows the clear walk; abort_k>0 re-asserts reset after that write.
  task automatic run_clear(input bit vld, input int abort_k);
    drive(vld, 5'd3, 32'h1111, vld, 5'd4, 32'h2222);
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      chk("clr_ardy", 64'(ifc.alu_ready), 64'(0));
      chk("clr_lrdy", 64'(ifc.lsu_ready), 64'(0));
      @(posedge clk); #1;
      chk("clr_we",   64'(ifc.rf_write_enable), 64'(1));
      chk("clr_rd",   64'(ifc.rf_rd),           64'(k));
      chk("clr_data", 64'(ifc.rf_write_data),   64'(0));
      chk("clr_init", 64'(ifc.init_done),       64'(k == 31));
      chk("clr_cnt",  64'(ifc.conflict_cnt),    64'(0));
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1 check_reset();
        return;
      end
      if (k == 31) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("post_clr_we",   64'(ifc.rf_write_enable), 64'(0));
    chk("post_clr_init", 64'(ifc.init_done),       64'(1));
  endtask

  typedef struct {
    bit          av; logic [4:0] ard; logic [31:0] adat;
    bit          lv; logic [4:0] lrd; logic [31:0] ldat;
    bit          e_ar; bit e_lr; bit e_we; logic [4:0] e_rd; logic [31:0] e_dat;
    int          e_cnt; bit e_last;
  } vec_t;

  vec_t tbl[11];

  bit          pv[2];
  logic [4:0]  prd[2];
  logic [31:0] pdat[2];
  int          m_last, m_cnt, g;
  bit          exp_we;

  initial begin
    tbl[0]  = '{1'b1, 5'd1,  32'hA1,       1'b1, 5'd9,  32'hB9,       1'b1, 1'b0, 1'b1, 5'd1,  32'hA1,       1, 1'b0};
    tbl[1]  = '{1'b1, 5'd2,  32'hA2,       1'b1, 5'd9,  32'hB9,       1'b0, 1'b1, 1'b1, 5'd9,  32'hB9,       2, 1'b1};
    tbl[2]  = '{1'b1, 5'd2,  32'hA2,       1'b1, 5'd10, 32'hBA,       1'b1, 1'b0, 1'b1, 5'd2,  32'hA2,       3, 1'b0};
    tbl[3]  = '{1'b1, 5'd3,  32'hA3,       1'b1, 5'd10, 32'hBA,       1'b0, 1'b1, 1'b1, 5'd10, 32'hBA,       4, 1'b1};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        4, 1'b1};
    tbl[5]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 4, 1'b0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234,     1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        4, 1'b1};
    tbl[7]  = '{1'b1, 5'd7,  32'hC0DE0007, 1'b1, 5'd8,  32'hC0DE0008, 1'b1, 1'b0, 1'b1, 5'd7,  32'hC0DE0007, 5, 1'b0};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFF0000, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF0000, 5, 1'b1};
    tbl[9]  = '{1'b1, 5'd0,  32'h55555555, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        5, 1'b0};
    tbl[10] = '{1'b1, 5'd12, 32'h0C,       1'b1, 5'd13, 32'h0D,       1'b0, 1'b1, 1'b1, 5'd13, 32'h0D,       6, 1'b1};

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1 check_reset();

    run_clear(1'b0, 0);

    // Directed vectors: readies checked mid-cycle, write port one edge later.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat);
      @(negedge clk);
      chk($sformatf("v%0d_ardy", i), 64'(ifc.alu_ready), 64'(tbl[i].e_ar));
      chk($sformatf("v%0d_lrdy", i), 64'(ifc.lsu_ready), 64'(tbl[i].e_lr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), 64'(ifc.rf_write_enable), 64'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_rd", i),   64'(ifc.rf_rd),         64'(tbl[i].e_rd));
        chk($sformatf("v%0d_data", i), 64'(ifc.rf_write_data), 64'(tbl[i].e_dat));
      end
      chk($sformatf("v%0d_cnt", i),  64'(ifc.conflict_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_last", i), 64'(ifc.last_grant),   64'(tbl[i].e_last));
    end

    // Random traffic against a queue-free model of pending requests.
    m_last = 1; m_cnt = 6;
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      for (int s = 0; s < 2; s++)
        if (!pv[s] && $urandom_range(3) != 0) begin
          pv[s]   = 1'b1;
          prd[s]  = 5'($urandom_range(31));
          pdat[s] = $urandom;
        end
      drive(pv[0], prd[0], pdat[0], pv[1], prd[1], pdat[1]);
      if (pv[0] && pv[1]) g = 1 - m_last;
      else if (pv[0])     g = 0;
      else if (pv[1])     g = 1;
      else                g = -1;
      if (pv[0] && pv[1] && m_cnt < CMAX) m_cnt++;
      @(negedge clk);
      chk("rnd_ardy", 64'(ifc.alu_ready), 64'(g == 0));
      chk("rnd_lrdy", 64'(ifc.lsu_ready), 64'(g == 1));
      @(posedge clk); #1;
      exp_we = (g >= 0) && (prd[g < 0 ? 0 : g] != 5'd0);
      chk("rnd_we", 64'(ifc.rf_write_enable), 64'(exp_we));
      if (exp_we) begin
        chk("rnd_rd",   64'(ifc.rf_rd),         64'(prd[g]));
        chk("rnd_data", 64'(ifc.rf_write_data), 64'(pdat[g]));
      end
      chk("rnd_cnt", 64'(ifc.conflict_cnt), 64'(m_cnt));
      if (g >= 0) begin
        m_last = g;
        pv[g]  = 1'b0;
      end
      chk("rnd_last", 64'(ifc.last_grant), 64'(m_last));
    end

    // Asynchronous reset mid-run, then a clear aborted after x11 and restarted from x1.
    drive(1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7);
    #2 rst = 1'b1;
    #1 check_reset();
    run_clear(1'b1, 11);
    @(posedge clk); #1;
    run_clear(1'b1, 0);
    chk("post_clr_cnt", 64'(ifc.conflict_cnt), 64'(0));

    // Hold both requesters busy past the counter range.
    for (int k = 1; k <= (1 << CNT_W) + 3; k++) begin
      drive(1'b1, 5'(k % 30 + 1), 32'(k), 1'b1, 5'(k % 30 + 1), 32'(k + 100));
      @(negedge clk);
      chk("sat_ardy", 64'(ifc.alu_ready), 64'(k % 2 == 1));
      chk("sat_lrdy", 64'(ifc.lsu_ready), 64'(k % 2 == 0));
      @(posedge clk); #1;
      chk("sat_cnt", 64'(ifc.conflict_cnt), 64'(k < CMAX ? k : CMAX));
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
